// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter
//   Two-master arbiter in front of a single-port synchronous memory.
//   At most one access is issued per cycle. Grants are combinational from the
//   ownership state and the requests. An unlocked conflict is resolved
//   round-robin. A master that wins with its lock bit set keeps ownership, but
//   only for MAX_HOLD consecutive grants while the other master is waiting.
//   Read data comes back one cycle after the grant and is routed to the master
//   that issued the read.
//
// Ports
//   ck, rst                     clock (rising edge), asynchronous active-high reset
//   mN_req/we/lock/addr/wdata   master N request, direction, lock, address, write data
//   mN_gnt                      master N access issued this cycle
//   mN_rvalid/rdata             master N read return (valid one cycle after the grant)
//   mem_ce/we/addr/wdata        memory command, zero when no access is issued
//   mem_rdata                   memory read data, one cycle after the read
module nano_mem_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [7:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [7:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_reg, last_next;   // master granted most recently
  logic [CNT_W-1:0]  cnt_reg, cnt_next;     // grants taken by the owner while the other waits

  // Per-master views of the request ports so both masters share one code path.
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [15:0] rdata [2];

  assign req  = {m1_req,  m0_req};
  assign we   = {m1_we,   m0_we};
  assign lock = {m1_lock, m0_lock};

  // Owner index and "the other master" while in an ownership state.
  logic own_idx;
  logic oth_idx;
  assign own_idx = (state_reg == OWN1);
  assign oth_idx = ~own_idx;

  // ---------------------------------------------------------------------------
  // Grant decision. Forced low during reset so nothing reaches the memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (req == 2'b11)
            // last_reg=1 means master 1 went last, so master 0 wins now.
            gnt = last_reg ? 2'b01 : 2'b10;
          else
            gnt = req;
        end
        OWN0:    gnt = {1'b0, req[0]};
        OWN1:    gnt = {req[1], 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // ---------------------------------------------------------------------------
  // Memory command mux: follows the granted master, all-zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ce    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;
    if (gnt[0]) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt[1]) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership FSM next state, hold counter and round-robin pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;

    // Only an actual grant moves the round-robin pointer; empty cycles keep it.
    if (gnt[0])
      last_next = 1'b0;
    else if (gnt[1])
      last_next = 1'b1;

    case (state_reg)
      IDLE: begin
        // Counter is kept at zero while idle, which also clears it on entry.
        cnt_next = '0;
        if (gnt[0] && lock[0])
          state_next = OWN0;
        else if (gnt[1] && lock[1])
          state_next = OWN1;
      end

      OWN0, OWN1: begin
        if (gnt[own_idx]) begin
          if (!lock[own_idx]) begin
            state_next = IDLE;
          end else if (req[oth_idx]) begin
            cnt_next = cnt_reg + 1'b1;
            // Hold budget spent: drop back to IDLE. The pointer already names
            // the owner, so the waiting master wins the next conflict.
            if (cnt_next == CNT_W'(MAX_HOLD))
              state_next = IDLE;
          end
        end else if (!req[own_idx] && !lock[own_idx]) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path, one per master. mem_rdata is passed straight through in
  // the cycle it is valid and captured so the output holds it afterwards.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic        valid_reg;
      logic [15:0] hold_reg;

      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          hold_reg  <= 16'h0000;
        end else begin
          valid_reg <= gnt[gi] & ~we[gi];
          if (valid_reg)
            hold_reg <= mem_rdata;
        end
      end

      assign rvalid[gi] = valid_reg;
      assign rdata[gi]  = valid_reg ? mem_rdata : hold_reg;
    end
  endgenerate

  assign m0_rvalid = rvalid[0];
  assign m0_rdata  = rdata[0];
  assign m1_rvalid = rvalid[1];
  assign m1_rdata  = rdata[1];

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb_nano_mem_arbiter
//   Directed bench for nano_mem_arbiter. A behavioural model (ownership,
//   pointer, hold count, shadow memory, pending reads) predicts every output on
//   each falling edge; directed scenarios also pin literal grant sequences.
module tb_nano_mem_arbiter;
  localparam int MAX_HOLD = 4;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [7:0]  m0_addr = 0;
  logic [15:0] m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [7:0]  m1_addr = 0;
  logic [15:0] m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_ce, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  always #5 ck = ~ck;

  nano_mem_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .ck(ck), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after the read.
  logic [15:0] mem [256];
  always @(posedge ck) begin
    if (mem_ce) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] ref_mem [256];
  int          own;          // -1 none, else owning master
  int          mlast;        // master granted most recently
  int          mhold;        // owner grants while the other waits
  bit          rv_pend [2];
  logic [15:0] rd_pend [2];
  logic [15:0] rd_held [2];
  int          gnt_log [$];

  always @(negedge ck) begin : cmp
    int e0, e1, g, lk, rq, orq;
    logic ewe;
    logic [7:0] eaddr;
    logic [15:0] ewd, erd0, erd1;
    if (rst) begin
      check("rst_m0_gnt",    32'(m0_gnt),    32'd0);
      check("rst_m1_gnt",    32'(m1_gnt),    32'd0);
      check("rst_mem_ce",    32'(mem_ce),    32'd0);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
      check("rst_m0_rdata",  32'(m0_rdata),  32'd0);
      check("rst_m1_rdata",  32'(m1_rdata),  32'd0);
      own = -1; mlast = 1; mhold = 0;
      rv_pend[0] = 0; rv_pend[1] = 0;
      rd_held[0] = 16'h0; rd_held[1] = 16'h0;
    end else begin
      e0 = 0; e1 = 0;
      if (own == 0)      e0 = int'(m0_req);
      else if (own == 1) e1 = int'(m1_req);
      else if (m0_req && m1_req) begin
        if (mlast == 1) e0 = 1; else e1 = 1;
      end else begin
        e0 = int'(m0_req); e1 = int'(m1_req);
      end
      ewe = 0; eaddr = 0; ewd = 0;
      if (e0 == 1)      begin ewe = m0_we; eaddr = m0_addr; ewd = m0_wdata; end
      else if (e1 == 1) begin ewe = m1_we; eaddr = m1_addr; ewd = m1_wdata; end
      erd0 = rv_pend[0] ? rd_pend[0] : rd_held[0];
      erd1 = rv_pend[1] ? rd_pend[1] : rd_held[1];

      check("m0_gnt",    32'(m0_gnt),    32'(e0));
      check("m1_gnt",    32'(m1_gnt),    32'(e1));
      check("mem_ce",    32'(mem_ce),    32'(e0 | e1));
      check("mem_we",    32'(mem_we),    32'(ewe));
      check("mem_addr",  32'(mem_addr),  32'(eaddr));
      check("mem_wdata", 32'(mem_wdata), 32'(ewd));
      check("m0_rvalid", 32'(m0_rvalid), 32'(rv_pend[0]));
      check("m0_rdata",  32'(m0_rdata),  32'(erd0));
      check("m1_rvalid", 32'(m1_rvalid), 32'(rv_pend[1]));
      check("m1_rdata",  32'(m1_rdata),  32'(erd1));

      if (m0_gnt || m1_gnt)
        $display("[%0t] grant m%0d %s addr=%02h wdata=%04h", $time, m1_gnt ? 1 : 0,
                 mem_we ? "WR" : "RD", mem_addr, mem_wdata);
      if (m0_gnt)      gnt_log.push_back(0);
      else if (m1_gnt) gnt_log.push_back(1);

      // Advance the model to the next cycle.
      for (int n = 0; n < 2; n++)
        if (rv_pend[n]) rd_held[n] = rd_pend[n];
      rv_pend[0] = (e0 == 1) && !m0_we;
      rv_pend[1] = (e1 == 1) && !m1_we;
      if (rv_pend[0]) rd_pend[0] = ref_mem[m0_addr];
      if (rv_pend[1]) rd_pend[1] = ref_mem[m1_addr];
      if (e0 == 1 && m0_we) ref_mem[m0_addr] = m0_wdata;
      if (e1 == 1 && m1_we) ref_mem[m1_addr] = m1_wdata;

      if (own < 0) begin
        if (e0 == 1 && m0_lock)      begin own = 0; mhold = 0; end
        else if (e1 == 1 && m1_lock) begin own = 1; mhold = 0; end
      end else begin
        g   = (own == 0) ? e0 : e1;
        lk  = (own == 0) ? int'(m0_lock) : int'(m1_lock);
        rq  = (own == 0) ? int'(m0_req)  : int'(m1_req);
        orq = (own == 0) ? int'(m1_req)  : int'(m0_req);
        if (g == 1) begin
          if (lk == 0) own = -1;
          else if (orq == 1) begin
            mhold++;
            if (mhold >= MAX_HOLD) own = -1;
          end
        end else if (rq == 0 && lk == 0) begin
          own = -1;
        end
      end
      if (e0 == 1)      mlast = 0;
      else if (e1 == 1) mlast = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_lock = 0; m0_we = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0;
  endtask

  // Compare the logged grant sequence with a literal; entry i expected = exp[i].
  task automatic check_seq(string name, int n, logic [15:0] exp);
    check({name, "_len"}, 32'(gnt_log.size()), 32'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      check(name, 32'(gnt_log[i]), 32'(exp[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'((i * 257) ^ 23130);
      ref_mem[i] = mem[i];
    end
    mem[8'h10]     = 16'h1234;
    ref_mem[8'h10] = 16'h1234;

    // Reset with a request already pending: no grant while rst is high.
    m0_req = 1; m0_addr = 8'h10;
    repeat (2) @(negedge ck);
    check("lit_rst_gnt",   32'(m0_gnt),   32'd0);
    check("lit_rst_ce",    32'(mem_ce),   32'd0);
    check("lit_rst_rdata", 32'(m0_rdata), 32'd0);

    // Single read, granted in the first cycle after reset release.
    step(); rst = 0;
    @(negedge ck);
    check("lit_rd_gnt",  32'(m0_gnt),   32'd1);
    check("lit_rd_addr", 32'(mem_addr), 32'h10);
    step(); m0_req = 0;
    @(negedge ck);
    check("lit_rd_rvalid", 32'(m0_rvalid), 32'd1);
    check("lit_rd_rdata",  32'(m0_rdata),  32'h1234);
    step();
    @(negedge ck);
    check("lit_rd_after_valid", 32'(m0_rvalid), 32'd0);
    check("lit_rd_after_data",  32'(m0_rdata),  32'h1234);

    // Write by m1.
    step(); m1_req = 1; m1_we = 1; m1_addr = 8'h22; m1_wdata = 16'hBEEF;
    @(negedge ck);
    check("lit_wr_gnt",   32'(m1_gnt),    32'd1);
    check("lit_wr_we",    32'(mem_we),    32'd1);
    check("lit_wr_addr",  32'(mem_addr),  32'h22);
    check("lit_wr_wdata", 32'(mem_wdata), 32'hBEEF);
    step(); m1_req = 0; m1_we = 0;
    @(negedge ck);
    check("lit_wr_no_rvalid", 32'(m1_rvalid), 32'd0);
    check("lit_wr_we_off",    32'(mem_we),    32'd0);

    // Conflict right after reset: m0, m1, m0, m1.
    step(); rst = 1;
    step(); rst = 0; m0_req = 1; m1_req = 1;
    gnt_log.delete();
    repeat (4) step();
    idle_all();
    check_seq("lit_rr_seq", 4, 16'b1010);

    // m1 locked for 10 cycles, then m0 asks while m1 still owns.
    m1_req = 1; m1_lock = 1;
    gnt_log.delete();
    repeat (10) step();
    check_seq("lit_lock_seq", 10, 16'h03FF);
    m0_req = 1;
    @(negedge ck);
    check("lit_lock_m1_keeps", 32'(m1_gnt), 32'd1);
    check("lit_lock_m0_waits", 32'(m0_gnt), 32'd0);
    step(); m1_req = 0; m1_lock = 0;
    @(negedge ck);
    check("lit_unlock_cycle_m0", 32'(m0_gnt), 32'd0);
    step();
    @(negedge ck);
    check("lit_after_unlock_m0", 32'(m0_gnt), 32'd1);
    step(); idle_all();

    // Starvation cap: m0 owns, m1 waits -> 4 m0 grants, m1, then m0 again.
    m0_req = 1; m0_lock = 1;
    step();
    m1_req = 1;
    gnt_log.delete();
    repeat (6) step();
    check_seq("lit_cap_seq", 6, 16'b010000);
    idle_all();
    repeat (2) step();

    // Lock released on the same grant that spends the hold budget.
    m0_req = 1; m0_lock = 1;
    step();
    m1_req = 1;
    gnt_log.delete();
    repeat (3) step();
    m0_lock = 0;
    repeat (2) step();
    check_seq("lit_cap_unlock_seq", 5, 16'b10000);
    idle_all();
    repeat (2) step();

    // Reset in the cycle after an m0 read grant.
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    step(); m0_req = 0; rst = 1;
    @(negedge ck);
    check("lit_midrst_rvalid", 32'(m0_rvalid), 32'd0);
    check("lit_midrst_rdata",  32'(m0_rdata),  32'd0);
    check("lit_midrst_ce",     32'(mem_ce),    32'd0);
    step(); rst = 0; m0_req = 1; m1_req = 1;
    @(negedge ck);
    check("lit_midrst_m0_wins", 32'(m0_gnt), 32'd1);
    check("lit_midrst_m1_loses", 32'(m1_gnt), 32'd0);
    step(); idle_all();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nano_mem_arbiter.md
NANO_MEM_ARBITER -- requirements
Module: nano_mem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive grants one locked master may hold while the other master requests.
REQ-002 Parameter CNT_W, default 3, width of the hold counter; SHALL hold the value MAX_HOLD.
REQ-003 ck  in  1  clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 mN_req  in  1  master N (N=0,1) access request.
REQ-006 mN_we  in  1  master N write (1) / read (0).
REQ-007 mN_lock  in  1  master N keeps ownership after the current grant.
REQ-008 mN_addr  in  8  master N word address.
REQ-009 mN_wdata  in  16  master N write data.
REQ-010 mN_gnt  out  1  access of master N issued this cycle.
REQ-011 mN_rvalid  out  1  master N read data valid.
REQ-012 mN_rdata  out  16  master N read data.
REQ-013 mem_ce  out  1  memory enable.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  8  memory address.
REQ-016 mem_wdata  out  16  memory write data.
REQ-017 mem_rdata  in  16  memory read data, valid one cycle after the read is issued.

Function
REQ-018 The block SHALL issue at most one memory access per cycle; mem_ce=1 only in a cycle where exactly one mN_gnt=1.
REQ-019 In a grant cycle, mem_we, mem_addr and mem_wdata SHALL equal mN_we, mN_addr and mN_wdata of the granted master (combinational path); mem_addr=0, mem_wdata=0 and mem_we=0 otherwise.
REQ-020 mN_gnt SHALL be combinational from the state and the requests: mN_gnt=1 implies mN_req=1, and m0_gnt & m1_gnt SHALL never both be 1.
REQ-021 A master SHALL hold req, we, addr and wdata stable until it samples gnt=1; an ungranted request SHALL NOT be dropped by the arbiter.
REQ-022 For a granted read, mN_rvalid SHALL be 1 exactly one cycle after the grant, with mN_rdata=mem_rdata; otherwise mN_rvalid=0 and mN_rdata holds its last value.
REQ-023 A write SHALL produce no rvalid.
REQ-024 FSM states: IDLE, OWN0, OWN1.
REQ-025 In IDLE, arbitration SHALL be round-robin: the master not granted last wins a conflict; a single requester wins immediately.
REQ-026 The last-granted register SHALL reset to master 1, so master 0 wins the first conflict.
REQ-027 IDLE -> OWNn SHALL occur when master n is granted with mn_lock=1.
REQ-028 In OWNn, only master n SHALL be granted, in every cycle it requests.
REQ-029 OWNn -> IDLE SHALL occur after a grant with mn_lock=0, or in any cycle with mn_req=0 and mn_lock=0.
REQ-030 Hold counter: cleared on entry to OWNn; incremented on each OWNn grant while the other master requests; held otherwise.
REQ-031 When the counter reaches MAX_HOLD, the FSM SHALL return to IDLE with last-granted=n, so the other master wins the next cycle regardless of lock.
REQ-032 Simultaneous lock deassert and counter expiry SHALL produce a single transition to IDLE.
REQ-033 Idle cycles with no request SHALL NOT change last-granted.

Reset
REQ-034 While rst=1: state=IDLE, counter=0, last-granted=1, all mN_gnt=0, mN_rvalid=0, mN_rdata=0, mem_ce=0, mem_we=0.
REQ-035 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset.
REQ-036 The first grant after reset SHALL be possible in the first clock cycle after rst deasserts.

Verification
REQ-037 Single read: m0 reads addr 0x10 while mem holds 0x1234 -> m0_gnt=1 in the same cycle, m0_rvalid=1 with m0_rdata=0x1234 in the next cycle.
REQ-038 Conflict after reset: m0 and m1 request in the same cycle, both unlocked, held -> grants alternate m0, m1, m0, m1.
REQ-039 Lock: m1 locks and holds req, m0 idle, for 10 cycles -> 10 consecutive m1 grants and the state stays OWN1.
REQ-040 Starvation cap, MAX_HOLD=4: m0 locks continuously and m1 requests -> 4 m0 grants, then m1_gnt=1, then the normal round-robin rule applies.
REQ-041 Write: m1 writes 0xBEEF to 0x22 -> mem_we=1, mem_addr=0x22, mem_wdata=0xBEEF for one cycle and no m1_rvalid.
REQ-042 Reset mid-read: rst asserts in the cycle after an m0 read grant -> m0_rvalid=0 and all outputs at reset values, and m0 wins the first conflict after release.
